// File: rtl/m6502_bus_controller.sv
// m6502_bus_controller: decodes the M6502 bus into RAM/ROM/I/O, inserts ROM wait states, runs the IRQ interval timer
module m6502_bus_controller #(
    parameter int          ROM_WAIT = 2,
    parameter logic [15:0] RAM_TOP  = 16'h7FFF,
    parameter logic [7:0]  IO_PAGE  = 8'hFE
) (
    input  logic        CLK_IN,
    input  logic        RES,
    input  logic [15:0] ADDRESS,
    input  logic        RW_N,
    input  logic        SYNC,
    input  logic [7:0]  CPU_WDATA,
    output logic [7:0]  CPU_RDATA,
    output logic        RDATA_OE,
    output logic        READY,
    output logic        IRQ_N,
    output logic [15:0] MEM_ADDR,
    output logic        RAM_CS,
    output logic        ROM_CS,
    output logic        MEM_WE,
    output logic [7:0]  MEM_WDATA,
    input  logic [7:0]  RAM_RDATA,
    input  logic [7:0]  ROM_RDATA
);
    localparam logic [3:0] WAIT_N = 4'(ROM_WAIT);
    logic        ram, io, rom, slow, io_wr, expire;
    logic [7:0]  off, io_rdata, last_pc;
    logic [3:0]  wait_cnt;
    logic [15:0] held_addr, reload, cnt;
    logic [2:0]  ctrl;
    logic        pend;
    assign off       = ADDRESS[7:0];
    assign ram       = ADDRESS <= RAM_TOP;
    assign io        = (ADDRESS[15:8] == IO_PAGE) && !ram;
    assign rom       = !ram && !io;
    assign slow      = rom && RW_N;
    assign io_wr     = io && !RW_N;
    assign expire    = ctrl[0] && (cnt == 16'd0);
    assign READY     = !(slow && (wait_cnt < WAIT_N));
    assign IRQ_N     = !(pend && ctrl[1]);
    assign RDATA_OE  = RW_N;
    assign MEM_ADDR  = ADDRESS;
    assign MEM_WDATA = CPU_WDATA;
    assign RAM_CS    = ram;
    assign ROM_CS    = rom;
    assign MEM_WE    = ram && !RW_N;
    assign CPU_RDATA = ram ? RAM_RDATA : rom ? ROM_RDATA : io_rdata;
    always_comb begin
        io_rdata = (off == 8'h00) ? reload[7:0] :
                   (off == 8'h01) ? reload[15:8] :
                   (off == 8'h02) ? {5'b0, ctrl} :
                   (off == 8'h03) ? {7'b0, pend} :
                   (off == 8'h04) ? cnt[7:0] :
                   (off == 8'h05) ? cnt[15:8] :
                   (off == 8'h06) ? last_pc : 8'hFF;
    end
    always_ff @(posedge CLK_IN) begin
        if (RES) begin
            wait_cnt  <= '0;
            held_addr <= 16'hFFFF;
            reload    <= '0;
            ctrl      <= '0;
            pend      <= 1'b0;
            cnt       <= '0;
            last_pc   <= '0;
        end else begin
            if (slow && ADDRESS != held_addr) begin
                wait_cnt  <= (WAIT_N == 4'd0) ? 4'd0 : 4'd1;
                held_addr <= ADDRESS;
            end else if (slow && wait_cnt < WAIT_N) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt  <= '0;
                held_addr <= ~ADDRESS;
            end
            if (SYNC) last_pc <= off;
            if (expire) begin
                if (ctrl[2]) cnt <= reload;
                else ctrl[0] <= 1'b0;
            end else if (ctrl[0]) begin
                cnt <= cnt - 16'd1;
            end
            if (io_wr && off == 8'h00) reload[7:0] <= CPU_WDATA;
            if (io_wr && off == 8'h01) reload[15:8] <= CPU_WDATA;
            // a CTRL write overrides the one-shot EN clear of the same edge
            if (io_wr && off == 8'h02) begin
                ctrl <= CPU_WDATA[2:0];
                if (CPU_WDATA[0] && !ctrl[0]) cnt <= reload;
            end
            pend <= expire || (pend && !(io_wr && off == 8'h03 && CPU_WDATA[0]));
        end
    end
endmodule

// File: tb/tb_m6502_bus_controller.sv
// tb_m6502_bus_controller: scoreboard bench driving CPU bus cycles against a behavioural model of decode, waits and timer
module tb_m6502_bus_controller;
    localparam int ROM_WAIT = 2;
    logic        CLK_IN = 1'b0;
    logic        RES, RW_N, SYNC;
    logic [15:0] ADDRESS;
    logic [7:0]  CPU_WDATA, RAM_RDATA, ROM_RDATA;
    logic [7:0]  CPU_RDATA, MEM_WDATA;
    logic [15:0] MEM_ADDR;
    logic        RDATA_OE, READY, IRQ_N, RAM_CS, ROM_CS, MEM_WE;

    m6502_bus_controller #(.ROM_WAIT(ROM_WAIT), .RAM_TOP(16'h7FFF), .IO_PAGE(8'hFE)) dut (
        .CLK_IN(CLK_IN), .RES(RES), .ADDRESS(ADDRESS), .RW_N(RW_N), .SYNC(SYNC),
        .CPU_WDATA(CPU_WDATA), .CPU_RDATA(CPU_RDATA), .RDATA_OE(RDATA_OE), .READY(READY),
        .IRQ_N(IRQ_N), .MEM_ADDR(MEM_ADDR), .RAM_CS(RAM_CS), .ROM_CS(ROM_CS), .MEM_WE(MEM_WE),
        .MEM_WDATA(MEM_WDATA), .RAM_RDATA(RAM_RDATA), .ROM_RDATA(ROM_RDATA)
    );

    always #5 CLK_IN = ~CLK_IN;

    typedef struct {
        logic        tmo;
        logic        ready, irq_n, ram_cs, rom_cs, we, oe;
        logic [7:0]  rdata, wdata;
        logic [15:0] addr;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0, cyc_no = 0;

    // Reference model state: what the CPU-visible registers and the current ROM access should be
    logic [15:0] m_reload, m_cnt, m_baddr;
    logic        m_en, m_irqen, m_auto, m_pend, m_busy;
    logic [7:0]  m_lpc;
    int          m_rem;

    task automatic chk(input string nm, input int cyc, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, want);
        end
    endtask

    always @(negedge CLK_IN) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.tmo) chk("stall_bound", e.cyc, 16'(READY), 16'd1);
            else begin
                chk("READY", e.cyc, 16'(READY), 16'(e.ready));
                chk("IRQ_N", e.cyc, 16'(IRQ_N), 16'(e.irq_n));
                chk("RAM_CS", e.cyc, 16'(RAM_CS), 16'(e.ram_cs));
                chk("ROM_CS", e.cyc, 16'(ROM_CS), 16'(e.rom_cs));
                chk("MEM_WE", e.cyc, 16'(MEM_WE), 16'(e.we));
                chk("RDATA_OE", e.cyc, 16'(RDATA_OE), 16'(e.oe));
                chk("CPU_RDATA", e.cyc, 16'(CPU_RDATA), 16'(e.rdata));
                chk("MEM_ADDR", e.cyc, MEM_ADDR, e.addr);
                chk("MEM_WDATA", e.cyc, 16'(MEM_WDATA), 16'(e.wdata));
            end
        end
    end

    function automatic logic [7:0] io_read(input logic [7:0] o);
        case (o)
            8'h00: return m_reload[7:0];
            8'h01: return m_reload[15:8];
            8'h02: return {5'b0, m_auto, m_irqen, m_en};
            8'h03: return {7'b0, m_pend};
            8'h04: return m_cnt[7:0];
            8'h05: return m_cnt[15:8];
            8'h06: return m_lpc;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_reset();
        m_reload = '0; m_cnt = '0; m_en = 0; m_irqen = 0; m_auto = 0;
        m_pend = 0; m_lpc = '0; m_busy = 0; m_baddr = '0; m_rem = 0;
    endtask

    task automatic cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd, input logic sync,
                         input logic res, input logic [7:0] ram_d, input logic [7:0] rom_d, output logic rdy);
        exp_t e;
        logic ram, io, rom, slow, old_en, expd;
        logic [15:0] r0;
        ADDRESS = a; RW_N = rw; CPU_WDATA = wd; SYNC = sync; RES = res;
        RAM_RDATA = ram_d; ROM_RDATA = rom_d;
        ram = a <= 16'h7FFF;
        io = !ram && a[15:8] == 8'hFE;
        rom = !ram && !io;
        slow = rom && rw;
        if (slow && !(m_busy && a == m_baddr)) m_rem = ROM_WAIT;
        rdy = !slow || m_rem == 0;
        e.tmo = 0; e.ready = rdy; e.irq_n = !(m_pend && m_irqen);
        e.ram_cs = ram; e.rom_cs = rom; e.we = ram && !rw; e.oe = rw;
        e.rdata = ram ? ram_d : rom ? rom_d : io_read(a[7:0]);
        e.wdata = wd; e.addr = a; e.cyc = cyc_no;
        sb.push_back(e);
        @(posedge CLK_IN);
        cyc_no++;
        if (res) model_reset();
        else begin
            if (slow && m_rem != 0) begin m_rem--; m_busy = 1; m_baddr = a; end
            else m_busy = 0;
            r0 = m_reload; old_en = m_en; expd = 0;
            if (m_en) begin
                if (m_cnt == 0) begin
                    expd = 1;
                    if (m_auto) m_cnt = r0; else m_en = 0;
                end else m_cnt = m_cnt - 1;
            end
            if (io && !rw) begin
                case (a[7:0])
                    8'h00: m_reload[7:0] = wd;
                    8'h01: m_reload[15:8] = wd;
                    8'h02: begin
                        if (wd[0] && !old_en) m_cnt = r0;
                        {m_auto, m_irqen, m_en} = wd[2:0];
                    end
                    8'h03: if (wd[0]) m_pend = 0;
                    default: ;
                endcase
            end
            if (expd) m_pend = 1;
            if (sync) m_lpc = a[7:0];
        end
        #1;
    endtask

    // One CPU access: repeats the bus cycle while the model says the CPU is stalled
    task automatic access(input logic [15:0] a, input logic rw, input logic [7:0] wd, input logic sync,
                          input logic [7:0] ram_d, input logic [7:0] rom_d);
        logic rdy;
        exp_t e;
        rdy = 0;
        for (int k = 0; k < 32 && !rdy; k++) cycle(a, rw, wd, sync, 1'b0, ram_d, rom_d, rdy);
        if (!rdy) begin
            e.tmo = 1; e.cyc = cyc_no;
            sb.push_back(e);
        end
    endtask

    task automatic rd(input logic [15:0] a);
        access(a, 1'b1, 8'h00, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        access(a, 1'b0, d, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    initial begin
        logic rdy;
        logic [15:0] a;
        logic [7:0] d;
        RES = 1; ADDRESS = 16'h0000; RW_N = 1; SYNC = 0; CPU_WDATA = 0; RAM_RDATA = 0; ROM_RDATA = 0;
        repeat (2) @(posedge CLK_IN);
        #1;
        model_reset();
        cycle(16'h0000, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, rdy);
        access(16'h1234, 1'b1, 8'h00, 1'b0, 8'h5A, 8'hC3);
        access(16'hFFFC, 1'b1, 8'h00, 1'b0, 8'h11, 8'h00);
        access(16'hFFFD, 1'b1, 8'h00, 1'b0, 8'h22, 8'hE0);
        access(16'hFFFD, 1'b1, 8'h00, 1'b0, 8'h22, 8'hE1);
        access(16'h9000, 1'b0, 8'hA5, 1'b0, 8'h33, 8'h44);
        wr(16'hFE00, 8'h03); wr(16'hFE01, 8'h00); wr(16'hFE02, 8'h07);
        repeat (6) rd(16'h0100);
        wr(16'hFE03, 8'h01);
        repeat (5) rd(16'hFE03);
        wr(16'hFE02, 8'h00);
        wr(16'hFE00, 8'h01); wr(16'hFE01, 8'h00); wr(16'hFE03, 8'h01);
        wr(16'hFE02, 8'h03);
        repeat (4) rd(16'h0200);
        rd(16'hFE02); rd(16'hFE04); rd(16'hFE05); rd(16'hFE03);
        wr(16'hFE03, 8'h01);
        wr(16'hFE02, 8'h07);
        rd(16'h0300);
        wr(16'hFE03, 8'h01);
        rd(16'hFE03); rd(16'hFE07);
        access(16'h12AB, 1'b1, 8'h00, 1'b1, 8'hEA, 8'h00);
        rd(16'hFE06);
        cycle(16'hFFF0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h77, rdy);
        cycle(16'hFFF0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 8'h77, rdy);
        rd(16'hFE02); rd(16'hFE04); rd(16'hFE05); rd(16'hFE03);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(3))
                0: a = 16'($urandom_range(16'h7FFF));
                1: a = 16'h8000 + 16'($urandom_range(16'h7DFF));
                2: a = {8'hFE, 8'($urandom_range(12))};
                default: a = {8'hFF, 8'($urandom)};
            endcase
            d = 8'($urandom);
            if (a[7:0] == 8'h01) d = 8'h00;
            if ($urandom_range(63) == 0) cycle(a, 1'b1, d, 1'b0, 1'b1, 8'($urandom), 8'($urandom), rdy);
            else access(a, 1'($urandom), d, 1'($urandom), 8'($urandom), 8'($urandom));
        end
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge CLK_IN);
        #1;
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
